// File: rtl/fpu_cvt_pkg.sv
// rtl/fpu_cvt_pkg.sv - shared types for the two-requester ftoi arbiter
package fpu_cvt_pkg;
  localparam int NREQ = 2;

  typedef logic [31:0] word_t;

  typedef struct packed {
    logic v;
    logic id;
  } cvt_tag_t;
endpackage

// File: rtl/fpu_resp_fifo.sv
// rtl/fpu_resp_fifo.sv - per-requester result FIFO, pointer pair plus full bit
module fpu_resp_fifo
  import fpu_cvt_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  push,
  input  word_t push_data,
  input  logic  pop,
  output word_t pop_data,
  output logic  full,
  output logic  empty
);
  localparam int AW = $clog2(DEPTH);

  word_t         mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full_q;
  logic          do_pop;

  // Equal pointers mean empty unless the full bit says the writer lapped the reader.
  assign empty    = (wr_ptr == rd_ptr) && !full_q;
  assign full     = full_q;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      full_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !do_pop) begin
        full_q <= ((wr_ptr + AW'(1)) == rd_ptr);
      end else if (do_pop && !push) begin
        full_q <= 1'b0;
      end
    end
  end

  overflow_a: assert property (@(posedge clk) disable iff (rst) !(push && full_q && !do_pop));
endmodule

// File: rtl/fpu_cvt_arbiter.sv
// rtl/fpu_cvt_arbiter.sv - round-robin sharing of one pipelined ftoi between two requesters
module fpu_cvt_arbiter
  import fpu_cvt_pkg::*;
#(
  parameter int NSTAGE     = 3,
  parameter int RESQ_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic  [NREQ-1:0]       req_valid,
  output logic  [NREQ-1:0]       req_ready,
  input  word_t [NREQ-1:0]       req_data,
  output logic  [NREQ-1:0]       resp_valid,
  input  logic  [NREQ-1:0]       resp_ready,
  output word_t [NREQ-1:0]       resp_data,
  output word_t                  cvt_x,
  input  word_t                  cvt_y,
  output logic                   busy
);
  localparam int CW = $clog2(RESQ_DEPTH) + 1;
  localparam logic [CW-1:0] CREDIT_MAX = CW'(RESQ_DEPTH);

  logic [CW-1:0]   credit [NREQ];
  logic [NREQ-1:0] elig;
  logic [NREQ-1:0] grant;
  logic [NREQ-1:0] push;
  logic [NREQ-1:0] pop;
  logic [NREQ-1:0] fifo_full;
  logic [NREQ-1:0] fifo_empty;
  logic            rr_ptr;
  logic            gid;
  logic            issue;
  cvt_tag_t        tag_pipe [NSTAGE+1];

  always_comb begin
    elig = '0;
    for (int i = 0; i < NREQ; i++) begin
      elig[i] = req_valid[i] && (credit[i] < CREDIT_MAX);
    end
  end

  always_comb begin
    grant = '0;
    if (!rst) begin
      if (elig[0] && elig[1]) begin
        grant[rr_ptr] = 1'b1;
      end else begin
        grant = elig;
      end
    end
  end

  assign req_ready  = grant;
  assign gid        = grant[1];
  assign issue      = |grant;
  assign resp_valid = ~fifo_empty;
  assign pop        = resp_valid & resp_ready;

  // The tag pipe mirrors the converter latency; its last entry lines up with cvt_y.
  always_ff @(posedge clk) begin
    if (rst) begin
      cvt_x  <= '0;
      rr_ptr <= 1'b0;
      for (int k = 0; k <= NSTAGE; k++) begin
        tag_pipe[k] <= '0;
      end
    end else begin
      tag_pipe[0] <= cvt_tag_t'{v: issue, id: gid};
      for (int k = 1; k <= NSTAGE; k++) begin
        tag_pipe[k] <= tag_pipe[k-1];
      end
      if (issue) begin
        cvt_x  <= req_data[gid];
        rr_ptr <= ~gid;
      end
    end
  end

  // Credits count in-flight plus queued results, so a FIFO push always has room.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (rst) begin
        credit[i] <= '0;
      end else if (grant[i] && !pop[i]) begin
        credit[i] <= credit[i] + CW'(1);
      end else if (pop[i] && !grant[i]) begin
        credit[i] <= credit[i] - CW'(1);
      end
    end
  end

  always_comb begin
    busy = |(~fifo_empty);
    for (int k = 0; k <= NSTAGE; k++) begin
      busy = busy | tag_pipe[k].v;
    end
  end

  for (genvar i = 0; i < NREQ; i++) begin : g_resp
    assign push[i] = tag_pipe[NSTAGE].v && (tag_pipe[NSTAGE].id == 1'(i));

    fpu_resp_fifo #(
      .DEPTH(RESQ_DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push[i]),
      .push_data (cvt_y),
      .pop       (pop[i]),
      .pop_data  (resp_data[i]),
      .full      (fifo_full[i]),
      .empty     (fifo_empty[i])
    );

    push_full_a: assert property (@(posedge clk) disable iff (rst) !(push[i] && fifo_full[i] && !pop[i]));
  end
endmodule
